// File: rtl/instr_fetch_unit.sv
// RV32I fetch front end: sequential PC, credit-limited imem requests, prefetch queue, redirect flush.
// First instruction 3 cycles after reset; imem requests hold until accepted; core stalls via inst_ready.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect,
  input  logic [31:0] redirect_pc
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef logic [CW-1:0] cnt_t;
  typedef logic [AW-1:0] ptr_t;

  logic [31:0] fetch_pc_q, fetch_pc_d;
  logic        req_vld_q, req_vld_d;
  logic [31:0] req_addr_q, req_addr_d;
  logic        stale_q, stale_d;
  cnt_t        live_q, live_d, drop_q, drop_d, cnt_q, cnt_d;
  ptr_t        q_rd_q, q_rd_d, q_wr_q, q_wr_d;
  ptr_t        pf_rd_q, pf_rd_d, pf_wr_q, pf_wr_d;

  logic [31:0] q_inst_q [DEPTH];
  logic [31:0] q_pc_q   [DEPTH];
  logic [31:0] pf_pc_q  [DEPTH];

  logic        accept, acc_drop, rsp_live, rsp_old, push, pop, pend_next, credit;
  logic [31:0] tgt_pc;
  cnt_t        live_after, drop_after;
  logic [CW+1:0] total;

  assign accept   = req_vld_q & imem_req_ready;
  // A request pending across a redirect belongs to the abandoned stream.
  assign acc_drop = accept & (redirect | stale_q);
  assign rsp_old  = imem_rsp_valid & (drop_q != '0);
  assign rsp_live = imem_rsp_valid & (drop_q == '0);
  assign push     = rsp_live & ~redirect;
  assign pop      = inst_valid & inst_ready & ~redirect;
  assign tgt_pc   = redirect_pc & 32'hFFFF_FFFC;

  assign live_after = live_q - cnt_t'(rsp_live);
  assign drop_after = drop_q - cnt_t'(rsp_old);

  always_comb begin
    live_d     = live_after;
    drop_d     = drop_after;
    cnt_d      = cnt_q;
    fetch_pc_d = fetch_pc_q;
    req_vld_d  = 1'b0;
    req_addr_d = req_addr_q;
    stale_d    = 1'b0;
    total      = '0;
    credit     = 1'b0;
    pend_next  = req_vld_q & ~imem_req_ready;

    if (redirect) begin
      live_d     = '0;
      drop_d     = drop_after + live_after + cnt_t'(accept);
      cnt_d      = '0;
      fetch_pc_d = tgt_pc;
    end else begin
      live_d = live_after + cnt_t'(accept & ~acc_drop);
      drop_d = drop_after + cnt_t'(acc_drop);
      cnt_d  = cnt_q + cnt_t'(push) - cnt_t'(pop);
      if (accept && !stale_q) fetch_pc_d = fetch_pc_q + 32'd4;
    end

    // Queue slots plus every outstanding fetch never exceed DEPTH, so responses always fit.
    total  = {2'b00, cnt_d} + {2'b00, live_d} + {2'b00, drop_d};
    credit = int'(total) < DEPTH;

    if (pend_next) begin
      req_vld_d  = 1'b1;
      req_addr_d = req_addr_q;
      stale_d    = stale_q | redirect;
    end else begin
      req_vld_d  = credit;
      req_addr_d = fetch_pc_d;
    end

    q_wr_d  = redirect ? '0 : (push ? q_wr_q + 1'b1 : q_wr_q);
    q_rd_d  = redirect ? '0 : (pop  ? q_rd_q + 1'b1 : q_rd_q);
    pf_wr_d = accept ? pf_wr_q + 1'b1 : pf_wr_q;
    pf_rd_d = imem_rsp_valid ? pf_rd_q + 1'b1 : pf_rd_q;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      fetch_pc_q <= RESET_PC;
      req_vld_q  <= 1'b0;
      req_addr_q <= RESET_PC;
      stale_q    <= 1'b0;
      live_q     <= '0;
      drop_q     <= '0;
      cnt_q      <= '0;
      q_rd_q     <= '0;
      q_wr_q     <= '0;
      pf_rd_q    <= '0;
      pf_wr_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      req_vld_q  <= req_vld_d;
      req_addr_q <= req_addr_d;
      stale_q    <= stale_d;
      live_q     <= live_d;
      drop_q     <= drop_d;
      cnt_q      <= cnt_d;
      q_rd_q     <= q_rd_d;
      q_wr_q     <= q_wr_d;
      pf_rd_q    <= pf_rd_d;
      pf_wr_q    <= pf_wr_d;
    end
  end

  // PC FIFO tracks every accepted fetch, dropped or not, so it pops once per response.
  always_ff @(posedge Clk) begin
    if (accept) pf_pc_q[pf_wr_q] <= req_addr_q;
    if (push) begin
      q_inst_q[q_wr_q] <= imem_rsp_data;
      q_pc_q[q_wr_q]   <= pf_pc_q[pf_rd_q];
    end
  end

  assign imem_req_valid = req_vld_q;
  assign imem_req_addr  = req_addr_q;
  assign inst_valid     = (cnt_q != '0);
  assign inst           = inst_valid ? q_inst_q[q_rd_q] : 32'h0000_0013;
  assign inst_pc        = inst_valid ? q_pc_q[q_rd_q] : 32'h0000_0000;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomised bench for instr_fetch_unit against a queue-level model of the fetch stream.
module tb_instr_fetch_unit;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data;
  logic        inst_valid, inst_ready, redirect;
  logic [31:0] inst, inst_pc, redirect_pc;

  always #5 Clk = ~Clk;

  instr_fetch_unit #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
    .Clk(Clk), .Reset(Reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .redirect(redirect), .redirect_pc(redirect_pc)
  );

  typedef struct { logic [31:0] addr; int due; int tag; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] data; } ent_t;

  mreq_t       memq[$];
  mreq_t       cur;
  ent_t        mq[$];
  int          cyc, epoch, lat_lo, lat_hi;
  logic        pend_stale;
  logic [31:0] exp_addr;
  int          n_chk, n_err, n_acc, n_pop, n_drop;
  logic        tk_acc_fresh, tk_pop;
  logic [31:0] tk_acc_addr, tk_pop_pc;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h0000_1357;
  endfunction

  task automatic model_clear();
    memq.delete(); mq.delete();
    imem_rsp_valid = 1'b0; imem_rsp_data = 32'h0;
    pend_stale = 1'b0; exp_addr = RESET_PC; epoch = 0;
    n_acc = 0; n_pop = 0; n_drop = 0;
    redirect = 1'b0; redirect_pc = 32'h0;
  endtask

  // Advance one clock: update the memory and the expected stream, then compare outputs.
  task automatic tick();
    logic s_rv, s_rr, s_rsp, s_iv, s_ir, s_redir, stale;
    logic [31:0] s_addr, s_rpc;
    ent_t e; mreq_t m; int L;
    s_rv = imem_req_valid; s_rr = imem_req_ready; s_addr = imem_req_addr;
    s_rsp = imem_rsp_valid; s_iv = inst_valid; s_ir = inst_ready;
    s_redir = redirect; s_rpc = redirect_pc;
    @(posedge Clk); #1;
    cyc++;
    tk_acc_fresh = 1'b0; tk_pop = 1'b0;
    if (s_rv && !s_rr) begin
      n_chk++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== s_addr) begin
        n_err++;
        $display("FAIL req_hold: valid=%b addr=%h, required valid=1 addr=%h", imem_req_valid, imem_req_addr, s_addr);
      end
    end
    if (s_iv && s_ir && !s_redir && mq.size() > 0) begin
      tk_pop = 1'b1; tk_pop_pc = mq[0].pc; void'(mq.pop_front()); n_pop++;
    end
    if (s_rsp) begin
      if (s_redir || cur.tag != epoch) n_drop++;
      else begin e.pc = cur.addr; e.data = memfn(cur.addr); mq.push_back(e); end
    end
    if (s_redir) begin
      mq.delete(); epoch++; exp_addr = s_rpc & 32'hFFFF_FFFC;
    end
    if (s_rv && s_rr) begin
      stale = s_redir || pend_stale;
      n_acc++;
      if (!stale) begin
        tk_acc_fresh = 1'b1; tk_acc_addr = s_addr;
        n_chk++;
        if (s_addr !== exp_addr) begin
          n_err++;
          $display("FAIL req_addr: got %h, required %h", s_addr, exp_addr);
        end
        exp_addr = exp_addr + 32'd4;
      end
      L = $urandom_range(lat_hi, lat_lo);
      m.addr = s_addr; m.due = cyc + L - 1; m.tag = stale ? -1 : epoch;
      memq.push_back(m);
      pend_stale = 1'b0;
    end else if (s_rv && s_redir) begin
      pend_stale = 1'b1;
    end
    if (memq.size() > 0 && memq[0].due <= cyc) begin
      cur = memq.pop_front();
      imem_rsp_valid = 1'b1; imem_rsp_data = memfn(cur.addr);
    end else begin
      imem_rsp_valid = 1'b0; imem_rsp_data = $urandom;
    end
    n_chk++;
    if (inst_valid !== (mq.size() != 0)) begin
      n_err++;
      $display("FAIL inst_valid: got %b, required %b", inst_valid, mq.size() != 0);
    end
    n_chk++;
    if (mq.size() != 0) begin
      if (inst !== mq[0].data || inst_pc !== mq[0].pc) begin
        n_err++;
        $display("FAIL head: inst=%h pc=%h, required inst=%h pc=%h", inst, inst_pc, mq[0].data, mq[0].pc);
      end
    end else if (inst !== 32'h13 || inst_pc !== 32'h0) begin
      n_err++;
      $display("FAIL empty_out: inst=%h pc=%h, required 00000013/00000000", inst, inst_pc);
    end
    if (imem_req_valid) begin
      n_chk++;
      if (mq.size() + memq.size() + (imem_rsp_valid ? 1 : 0) >= DEPTH) begin
        n_err++;
        $display("FAIL credit: queued=%0d outstanding=%0d with request raised", mq.size(), memq.size() + (imem_rsp_valid ? 1 : 0));
      end
    end
  endtask

  task automatic do_reset();
    Reset = 1'b0;
    imem_req_ready = 1'b0; inst_ready = 1'b0;
    model_clear();
    repeat (2) @(posedge Clk);
    #1 Reset = 1'b1;
  endtask

  task automatic test_reset();
    int edges;
    Reset = 1'b0; imem_req_ready = 1'b0; inst_ready = 1'b0;
    model_clear();
    @(posedge Clk); #3;
    n_chk++;
    if (imem_req_valid !== 1'b0 || imem_req_addr !== RESET_PC) begin
      n_err++; $display("FAIL reset_req: valid=%b addr=%h, required 0/%h", imem_req_valid, imem_req_addr, RESET_PC);
    end
    n_chk++;
    if (inst_valid !== 1'b0 || inst !== 32'h13 || inst_pc !== 32'h0) begin
      n_err++; $display("FAIL reset_inst: v=%b inst=%h pc=%h, required 0/00000013/00000000", inst_valid, inst, inst_pc);
    end
    @(posedge Clk); #1;
    Reset = 1'b1; imem_req_ready = 1'b1; lat_lo = 1; lat_hi = 1;
    edges = 0;
    for (int i = 1; i <= 8 && edges == 0; i++) begin
      tick();
      if (inst_valid) edges = i;
    end
    n_chk++;
    if (edges != 3) begin
      n_err++; $display("FAIL first_latency: got %0d cycles, required 3", edges);
    end
    n_chk++;
    if (inst_pc !== RESET_PC || inst !== memfn(RESET_PC)) begin
      n_err++; $display("FAIL first_inst: pc=%h inst=%h, required %h/%h", inst_pc, inst, RESET_PC, memfn(RESET_PC));
    end
  endtask

  task automatic test_sequential();
    int k;
    do_reset();
    imem_req_ready = 1'b1; inst_ready = 1'b1; lat_lo = 1; lat_hi = 1;
    k = 0;
    repeat (30) begin
      tick();
      if (tk_pop) begin
        n_chk++;
        if (tk_pop_pc !== 32'(k * 4)) begin
          n_err++; $display("FAIL seq_pc: got %h, required %h", tk_pop_pc, 32'(k * 4));
        end
        k++;
      end
    end
    n_chk++;
    if (k < 20) begin
      n_err++; $display("FAIL seq_throughput: consumed %0d, required at least 20", k);
    end
  endtask

  task automatic test_credit();
    do_reset();
    imem_req_ready = 1'b1; inst_ready = 1'b0; lat_lo = 1; lat_hi = 1;
    repeat (12) tick();
    n_chk++;
    if (n_acc != DEPTH || imem_req_valid !== 1'b0) begin
      n_err++; $display("FAIL credit_fill: accepts=%0d valid=%b, required %0d/0", n_acc, imem_req_valid, DEPTH);
    end
    inst_ready = 1'b1;
    tick();
    inst_ready = 1'b0;
    repeat (8) tick();
    n_chk++;
    if (n_acc != DEPTH + 1 || imem_req_valid !== 1'b0 || n_pop != 1) begin
      n_err++; $display("FAIL credit_refill: accepts=%0d valid=%b pops=%0d, required %0d/0/1", n_acc, imem_req_valid, n_pop, DEPTH + 1);
    end
  endtask

  task automatic test_stall_redirect();
    logic [31:0] first;
    logic got;
    do_reset();
    imem_req_ready = 1'b0; inst_ready = 1'b1; lat_lo = 1; lat_hi = 1;
    tick();
    redirect = 1'b1; redirect_pc = 32'h100;
    tick();
    redirect = 1'b0;
    repeat (4) begin
      tick();
      n_chk++;
      if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
        n_err++; $display("FAIL stall_hold: valid=%b addr=%h, required 1/00000000", imem_req_valid, imem_req_addr);
      end
    end
    imem_req_ready = 1'b1;
    got = 1'b0; first = 32'h0;
    for (int i = 0; i < 20 && !inst_valid; i++) begin
      tick();
      if (tk_acc_fresh && !got) begin got = 1'b1; first = tk_acc_addr; end
    end
    n_chk++;
    if (!got || first !== 32'h100) begin
      n_err++; $display("FAIL stall_next_addr: got %h (seen=%b), required 00000100", first, got);
    end
    n_chk++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || n_drop != 1) begin
      n_err++; $display("FAIL stall_first_pc: v=%b pc=%h drops=%0d, required 1/00000100/1", inst_valid, inst_pc, n_drop);
    end
  endtask

  task automatic test_inflight_redirect();
    do_reset();
    imem_req_ready = 1'b1; inst_ready = 1'b1; lat_lo = 4; lat_hi = 4;
    for (int i = 0; i < 10 && n_acc < 3; i++) tick();
    redirect = 1'b1; redirect_pc = 32'h203;
    tick();
    redirect = 1'b0;
    n_chk++;
    if (inst_valid !== 1'b0) begin
      n_err++; $display("FAIL inflight_flush: inst_valid=%b, required 0", inst_valid);
    end
    for (int i = 0; i < 30 && !tk_pop; i++) tick();
    n_chk++;
    if (!tk_pop || tk_pop_pc !== 32'h200 || n_drop < 3) begin
      n_err++; $display("FAIL inflight_restart: popped=%b pc=%h drops=%0d, required 1/00000200/>=3", tk_pop, tk_pop_pc, n_drop);
    end
  endtask

  task automatic test_redirect_rsp();
    int p0, d0;
    do_reset();
    imem_req_ready = 1'b1; inst_ready = 1'b1; lat_lo = 1; lat_hi = 1;
    for (int i = 0; i < 20 && !(imem_rsp_valid && inst_valid); i++) tick();
    redirect = 1'b1; redirect_pc = 32'h40;
    p0 = n_pop; d0 = n_drop;
    tick();
    redirect = 1'b0;
    n_chk++;
    if (inst_valid !== 1'b0 || n_pop != p0 || n_drop != d0 + 1) begin
      n_err++; $display("FAIL redir_rsp: v=%b pops=+%0d drops=+%0d, required 0/+0/+1", inst_valid, n_pop - p0, n_drop - d0);
    end
    for (int i = 0; i < 20 && !inst_valid; i++) tick();
    n_chk++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h40) begin
      n_err++; $display("FAIL redir_rsp_next: v=%b pc=%h, required 1/00000040", inst_valid, inst_pc);
    end
  endtask

  task automatic test_wrap();
    logic [31:0] a[2];
    int n;
    do_reset();
    imem_req_ready = 1'b1; inst_ready = 1'b1; lat_lo = 1; lat_hi = 1;
    repeat (3) tick();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    n = 0; a[0] = 32'h1; a[1] = 32'h1;
    for (int i = 0; i < 20 && n < 2; i++) begin
      tick();
      if (tk_acc_fresh) begin a[n] = tk_acc_addr; n++; end
    end
    n_chk++;
    if (a[0] !== 32'hFFFF_FFFC || a[1] !== 32'h0) begin
      n_err++; $display("FAIL wrap: got %h,%h, required fffffffc,00000000", a[0], a[1]);
    end
  endtask

  task automatic test_random();
    do_reset();
    lat_lo = 1; lat_hi = 5;
    repeat (3000) begin
      imem_req_ready = ($urandom % 4) != 0;
      inst_ready = ($urandom % 3) != 0;
      redirect = ($urandom % 20) == 0;
      redirect_pc = $urandom;
      tick();
    end
    redirect = 1'b0;
    n_chk++;
    if (n_pop < 100) begin
      n_err++; $display("FAIL random_progress: consumed %0d, required at least 100", n_pop);
    end
  endtask

  task automatic test_midreset();
    logic got;
    imem_req_ready = 1'b1; inst_ready = 1'b1; lat_lo = 1; lat_hi = 3;
    repeat (10) tick();
    Reset = 1'b0;
    #1;
    n_chk++;
    if (imem_req_valid !== 1'b0 || imem_req_addr !== RESET_PC || inst_valid !== 1'b0 || inst !== 32'h13 || inst_pc !== 32'h0) begin
      n_err++; $display("FAIL midreset: rv=%b addr=%h iv=%b inst=%h pc=%h, required 0/%h/0/00000013/00000000",
                        imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc, RESET_PC);
    end
    model_clear();
    @(posedge Clk); #1;
    Reset = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      tick();
      if (tk_acc_fresh) got = 1'b1;
    end
    n_chk++;
    if (!got || tk_acc_addr !== RESET_PC) begin
      n_err++; $display("FAIL midreset_restart: seen=%b addr=%h, required 1/%h", got, tk_acc_addr, RESET_PC);
    end
  endtask

  initial begin
    n_chk = 0; n_err = 0; cyc = 0; lat_lo = 1; lat_hi = 1;
    Reset = 1'b0; imem_req_ready = 1'b0; inst_ready = 1'b0;
    tk_acc_fresh = 1'b0; tk_pop = 1'b0; tk_acc_addr = 32'h0; tk_pop_pc = 32'h0;
    cur.addr = 32'h0; cur.due = 0; cur.tag = -1;
    model_clear();
    test_reset();
    test_sequential();
    test_credit();
    test_stall_redirect();
    test_inflight_redirect();
    test_redirect_rsp();
    test_wrap();
    test_random();
    test_midreset();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction fetch front end that feeds the RV32I core's decode/execute datapath.
- Generates sequential word-aligned fetch addresses from its own PC.
- Issues them to a variable-latency instruction memory over a valid/ready request channel with in-order responses.
- Buffers returned instructions and their PCs in a small prefetch queue, presented to the core over a valid/ready handshake.
- Accepts a redirect (taken branch/jump) from the core, flushes queued and in-flight fetches, and restarts at the target.

Parameters:
RESET_PC, 32'h0000_0000, fetch address after reset
DEPTH, 4, prefetch queue entries; also caps total outstanding requests (power of 2, >=2)

Ports:
Clk  input  1  clock, rising edge
Reset  input  1  asynchronous, active-low reset
imem_req_valid  output  1  fetch request valid
imem_req_ready  input  1  memory accepts request
imem_req_addr  output  32  fetch word address, bits [1:0] always 0
imem_rsp_valid  input  1  response valid; one per accepted request, in order, no backpressure
imem_rsp_data  input  32  returned instruction word
inst_valid  output  1  queue head valid toward core
inst_ready  input  1  core consumes head
inst  output  32  head instruction; 32'h0000_0013 (NOP) when queue empty
inst_pc  output  32  PC of head instruction; 0 when empty
redirect  input  1  single-cycle redirect request
redirect_pc  input  32  redirect target; bits [1:0] ignored (forced to 0)

Behaviour:
- Clock and reset: one clock domain, Clk. Reset is asynchronous, active-low.
- Reset values: fetch_pc=RESET_PC; queue empty; outstanding counters=0; imem_req_valid=0; imem_req_addr=RESET_PC; inst_valid=0; inst=32'h13; inst_pc=0.
- Credit rule: queue_count + live_outstanding + drop_outstanding < DEPTH permits raising imem_req_valid. This guarantees a response never finds the queue full.
- Request handshake:
  - Once imem_req_valid is asserted, it and imem_req_addr stay stable until imem_req_valid && imem_req_ready. Redirect does not retract a pending request.
  - On accept, fetch_pc += 4 (32-bit wrap, 0xFFFF_FFFC -> 0) and the outstanding counter increments.
  - A request accepted in the redirect cycle, or already pending when redirect arrives, is counted as drop.
  - No new request is raised in the cycle redirect=1; earliest new request is the next cycle, at the redirect address.
- Responses:
  - If drop_outstanding > 0, the response is discarded and drop_outstanding decrements.
  - Otherwise data and its PC are pushed to the queue and live_outstanding decrements.
  - PC per entry is recorded at request acceptance in a DEPTH-deep PC FIFO.
- Consume: when inst_valid && inst_ready, pop the head; the next entry appears the following cycle. Zero-latency bypass is not required. Push and pop in the same cycle are both honoured; count is unchanged.
- Redirect (redirect=1):
  - Queue is flushed (count=0, inst_valid=0 next cycle), and a same-cycle pop is ignored.
  - drop_outstanding += live_outstanding, live_outstanding=0.
  - A same-cycle response counts as drop.
  - fetch_pc <= {redirect_pc[31:2],2'b00}.
  - Back-to-back redirects: the last one wins; all earlier in-flight responses are dropped.
- Latency: with memory ready and 1-cycle response, first inst_valid appears 3 cycles after Reset deasserts (request, response, queue register).
- Reset asserted mid-operation clears all state immediately. The memory is reset by the same signal, so no stale responses return.

Test Plan:
- Reset release, 1-cycle memory always ready -> requests 0x0,0x4,0x8,...; inst_pc 0x0,0x4,0x8 in order with matching data; inst_valid after 3 cycles.
- inst_ready=0 held -> exactly DEPTH=4 requests issued, then imem_req_valid=0; after 1 pop, exactly 1 more request.
- imem_req_ready=0 for 5 cycles while redirect to 0x100 pulses -> addr stays 0x0 until accepted; its response is dropped; next request is 0x100; first inst_pc=0x100.
- 3 requests in flight (4-cycle latency), redirect_pc=0x203 -> all 3 responses discarded, queue empty, next addr 0x200.
- Redirect coincident with a response and inst_ready=1 -> response dropped, no pop counted, inst_valid=0 next cycle.
- Redirect to 0xFFFF_FFFC -> fetch addresses 0xFFFF_FFFC then 0x0000_0000.
